// File: rtl/fwd_pkg.sv
// Forwarding select codes shared by the ID comparator muxes, the EX forwarding unit
// and the branch forwarding scoreboard.
package fwd_pkg;

  localparam int unsigned FWD_RF = 0;
  localparam int unsigned FWD_NSTAGE_DEFAULT = 3;
  localparam int unsigned FWD_MDU = FWD_NSTAGE_DEFAULT + 1;

  // Select width: register file, one code per stage, plus the MDU write port.
  function automatic int unsigned fwd_selw(input int unsigned nstage);
    return $clog2(nstage + 2);
  endfunction

  function automatic int unsigned fwd_mdu(input int unsigned nstage);
    return nstage + 1;
  endfunction

endpackage

// File: rtl/mdu_scoreboard.sv
// Per-register pending bits and outstanding-write count for the multi-cycle MDU,
// with a combinational lookup port for the ID-stage operands.
module mdu_scoreboard
  import fwd_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NSRC    = 2,
  parameter int MAX_OUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue,
  input  logic [REG_AW-1:0]      issue_rd,
  input  logic                   done,
  input  logic [REG_AW-1:0]      done_rd,
  input  logic [NSRC*REG_AW-1:0] lookup_rd,
  output logic [NSRC-1:0]        lookup_pending,
  output logic                   full
);

  localparam int NREG = 2 ** REG_AW;
  localparam int CW   = $clog2(MAX_OUT + 1);

  logic [NREG-1:0] pending_reg, pending_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            issue_ok, done_ok;

  assign full     = (cnt_reg == CW'(MAX_OUT));
  assign issue_ok = issue && (issue_rd != '0) && !full;
  // A done with no matching pending bit is a stray write and must not touch the count.
  assign done_ok  = done && pending_reg[done_rd];

  // Issue is applied after done so a same-register pair leaves the bit set.
  always_comb begin
    pending_next = pending_reg;
    cnt_next     = cnt_reg;
    if (done_ok) begin
      pending_next[done_rd] = 1'b0;
      cnt_next              = cnt_next - CW'(1);
    end
    if (issue_ok) begin
      pending_next[issue_rd] = 1'b1;
      cnt_next               = cnt_next + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
      cnt_reg     <= '0;
    end else begin
      pending_reg <= pending_next;
      cnt_reg     <= cnt_next;
    end
  end

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_lookup
    assign lookup_pending[gi] = pending_reg[lookup_rd[gi*REG_AW +: REG_AW]];
  end

  a_no_issue_when_full: assert property (@(posedge clk) disable iff (rst) !(issue && full));

endmodule

// File: rtl/branch_fwd_scoreboard.sv
// ID-stage branch operand forwarding, readiness/MDU hazard stall and stall watchdog.
// Optional BRANCH_STALL_STATS_EN adds per-hazard-class stall cycle counters.
module branch_fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int REG_AW        = 5,
  parameter int NSRC          = 2,
  parameter int NSTAGE        = 3,
  parameter int MAX_OUT       = 4,
  parameter int STALL_TIMEOUT = 64,
  localparam int SELW         = fwd_selw(NSTAGE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic                     id_is_branch,
  input  logic [NSRC*REG_AW-1:0]   id_src,
  input  logic [NSRC-1:0]          id_src_used,
  input  logic [NSTAGE*REG_AW-1:0] stage_rd,
  input  logic [NSTAGE-1:0]        stage_we,
  input  logic [NSTAGE-1:0]        stage_rdy,
  input  logic                     mdu_issue,
  input  logic [REG_AW-1:0]        mdu_issue_rd,
  input  logic                     mdu_done,
  input  logic [REG_AW-1:0]        mdu_done_rd,
  output logic [NSRC*SELW-1:0]     fwd_sel,
  output logic                     stall,
  output logic                     mdu_full,
  output logic                     hazard_timeout
`ifdef BRANCH_STALL_STATS_EN
  ,
  output logic [31:0]              stat_ready_stalls,
  output logic [31:0]              stat_mdu_stalls
`endif
);

  localparam int WW = $clog2(STALL_TIMEOUT + 1);

  logic [REG_AW-1:0] src [NSRC];
  logic [SELW-1:0]   sel [NSRC];
  logic [NSRC-1:0]   src_pending, ready_haz, mdu_haz;
  logic              hit, hit_rdy;
  logic [SELW-1:0]   hit_sel;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    assign src[gi]                  = id_src[gi*REG_AW +: REG_AW];
    assign fwd_sel[gi*SELW +: SELW] = sel[gi];
  end

  mdu_scoreboard #(
    .REG_AW (REG_AW),
    .NSRC   (NSRC),
    .MAX_OUT(MAX_OUT)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .issue         (mdu_issue),
    .issue_rd      (mdu_issue_rd),
    .done          (mdu_done),
    .done_rd       (mdu_done_rd),
    .lookup_rd     (id_src),
    .lookup_pending(src_pending),
    .full          (mdu_full)
  );

  always_comb begin
    hit     = 1'b0;
    hit_rdy = 1'b0;
    hit_sel = SELW'(FWD_RF);
    for (int i = 0; i < NSRC; i++) begin
      sel[i]       = SELW'(FWD_RF);
      ready_haz[i] = 1'b0;
      mdu_haz[i]   = 1'b0;
      hit          = 1'b0;
      hit_rdy      = 1'b0;
      hit_sel      = SELW'(FWD_RF);
      // Walk from WB towards EX so the nearest writer ends up selected.
      for (int k = NSTAGE - 1; k >= 0; k--) begin
        if (stage_we[k] && (stage_rd[k*REG_AW +: REG_AW] == src[i])) begin
          hit     = 1'b1;
          hit_rdy = stage_rdy[k];
          hit_sel = SELW'(k + 1);
        end
      end
      if ((src[i] != '0) && id_src_used[i]) begin
        if (hit) begin
          sel[i]       = hit_sel;
          ready_haz[i] = !hit_rdy && id_valid && id_is_branch;
        end else if (mdu_done && (mdu_done_rd == src[i])) begin
          sel[i] = SELW'(fwd_mdu(NSTAGE));
        end else begin
          mdu_haz[i] = src_pending[i] && id_valid;
        end
      end
    end
  end

  assign stall = (|ready_haz) || (|mdu_haz);

  logic [WW-1:0] stall_ctr_reg, stall_ctr_next;
  logic          timeout_reg;

  always_comb begin
    stall_ctr_next = '0;
    if (stall) begin
      stall_ctr_next = (stall_ctr_reg == WW'(STALL_TIMEOUT)) ? stall_ctr_reg
                                                              : stall_ctr_reg + WW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_ctr_reg <= '0;
      timeout_reg   <= 1'b0;
    end else begin
      stall_ctr_reg <= stall_ctr_next;
      if (stall_ctr_next == WW'(STALL_TIMEOUT)) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign hazard_timeout = timeout_reg;

`ifdef BRANCH_STALL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ready_stalls <= '0;
      stat_mdu_stalls   <= '0;
    end else begin
      if (|ready_haz) stat_ready_stalls <= stat_ready_stalls + 32'd1;
      if (|mdu_haz)   stat_mdu_stalls   <= stat_mdu_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_fwd_scoreboard.sv
// Scoreboard-style bench for branch_fwd_scoreboard: each cycle pushes its expected
// {fwd_sel, stall, mdu_full, hazard_timeout} and the observed value captured off-edge.
module tb_branch_fwd_scoreboard;

  localparam int REG_AW = 5;
  localparam int NSRC   = 2;
  localparam int NSTAGE = 3;
  localparam int SELW   = 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     id_valid, id_is_branch;
  logic [NSRC*REG_AW-1:0]   id_src;
  logic [NSRC-1:0]          id_src_used;
  logic [NSTAGE*REG_AW-1:0] stage_rd;
  logic [NSTAGE-1:0]        stage_we, stage_rdy;
  logic                     mdu_issue, mdu_done;
  logic [REG_AW-1:0]        mdu_issue_rd, mdu_done_rd;
  logic [NSRC*SELW-1:0]     fwd_sel;
  logic                     stall, mdu_full, hazard_timeout;
`ifdef BRANCH_STALL_STATS_EN
  logic [31:0]              stat_ready_stalls, stat_mdu_stalls;
`endif

  branch_fwd_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_is_branch  (id_is_branch),
    .id_src        (id_src),
    .id_src_used   (id_src_used),
    .stage_rd      (stage_rd),
    .stage_we      (stage_we),
    .stage_rdy     (stage_rdy),
    .mdu_issue     (mdu_issue),
    .mdu_issue_rd  (mdu_issue_rd),
    .mdu_done      (mdu_done),
    .mdu_done_rd   (mdu_done_rd),
    .fwd_sel       (fwd_sel),
    .stall         (stall),
    .mdu_full      (mdu_full),
    .hazard_timeout(hazard_timeout)
`ifdef BRANCH_STALL_STATS_EN
    ,
    .stat_ready_stalls(stat_ready_stalls),
    .stat_mdu_stalls  (stat_mdu_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [8:0] v;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] obs_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  function automatic logic [8:0] mk(input int s1, input int s0, input bit st,
                                    input bit fu, input bit to);
    return {3'(s1), 3'(s0), st, fu, to};
  endfunction

  task automatic set_id(input bit v, input bit br, input int s1, input int s0,
                        input logic [1:0] used);
    id_valid     = v;
    id_is_branch = br;
    id_src       = {5'(s1), 5'(s0)};
    id_src_used  = used;
  endtask

  task automatic set_stg(input logic [2:0] we, input logic [2:0] rdy,
                         input int r2, input int r1, input int r0);
    stage_we  = we;
    stage_rdy = rdy;
    stage_rd  = {5'(r2), 5'(r1), 5'(r0)};
  endtask

  task automatic set_mdu(input bit iss, input int ird, input bit dn, input int drd);
    mdu_issue    = iss;
    mdu_issue_rd = 5'(ird);
    mdu_done     = dn;
    mdu_done_rd  = 5'(drd);
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 2'b00);
    set_stg(3'b000, 3'b111, 0, 0, 0);
    set_mdu(0, 0, 0, 0);
  endtask

  // Inputs are already driven; record expectation, sample mid-cycle, advance to next cycle.
  task automatic step(input string nm, input logic [8:0] v);
    exp_t e;
    e.name = nm;
    e.v    = v;
    exp_q.push_back(e);
    @(negedge clk);
    obs_q.push_back({fwd_sel, stall, mdu_full, hazard_timeout});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [8:0] o;
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step("reset_idle", mk(0, 0, 0, 0, 0));
    set_id(1, 1, 0, 8, 2'b01);
    step("reset_no_pending", mk(0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_errors++;
        $display("FAIL %s: no observation, required %b", e.name, e.v);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.v) begin
          n_errors++;
          $display("FAIL %s: got %b required %b", e.name, o, e.v);
        end else $display("check %s: %b", e.name, o);
      end
    end
  endtask

  task automatic test_operand_match();
    exp_t e;
    logic [8:0] o;
    set_id(1, 1, 9, 8, 2'b11);
    set_stg(3'b110, 3'b111, 8, 8, 5);
    step("match_mem_over_wb", mk(0, 2, 0, 0, 0));
    set_stg(3'b111, 3'b111, 8, 8, 9);
    step("match_ex_rt", mk(1, 2, 0, 0, 0));
    set_id(1, 1, 9, 8, 2'b01);
    step("match_rt_unused", mk(0, 2, 0, 0, 0));
    set_id(1, 0, 9, 8, 2'b11);
    set_stg(3'b001, 3'b110, 0, 0, 8);
    step("nonbranch_no_rdy_stall", mk(0, 1, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_errors++;
        $display("FAIL %s: no observation, required %b", e.name, e.v);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.v) begin
          n_errors++;
          $display("FAIL %s: got %b required %b", e.name, o, e.v);
        end else $display("check %s: %b", e.name, o);
      end
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    logic [8:0] o;
    set_id(1, 1, 0, 8, 2'b01);
    set_stg(3'b001, 3'b110, 0, 0, 8);
    step("load_use_stall", mk(0, 1, 1, 0, 0));
    set_stg(3'b010, 3'b111, 0, 8, 0);
    step("load_use_mem_fwd", mk(0, 2, 0, 0, 0));
    set_id(0, 1, 0, 8, 2'b01);
    set_stg(3'b001, 3'b110, 0, 0, 8);
    step("load_use_id_invalid", mk(0, 1, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_errors++;
        $display("FAIL %s: no observation, required %b", e.name, e.v);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.v) begin
          n_errors++;
          $display("FAIL %s: got %b required %b", e.name, o, e.v);
        end else $display("check %s: %b", e.name, o);
      end
    end
  endtask

  task automatic test_mdu();
    exp_t e;
    logic [8:0] o;
    idle();
    set_mdu(1, 10, 0, 0);
    step("mdu_issue10", mk(0, 0, 0, 0, 0));
    set_mdu(0, 0, 0, 0);
    set_id(1, 1, 0, 10, 2'b01);
    for (int i = 0; i < 3; i++) step("mdu_wait", mk(0, 0, 1, 0, 0));
    set_id(1, 0, 0, 10, 2'b01);
    step("mdu_wait_nonbranch", mk(0, 0, 1, 0, 0));
    set_id(1, 1, 0, 10, 2'b01);
    set_mdu(0, 0, 1, 10);
    step("mdu_done_bypass", mk(0, 4, 0, 0, 0));
    set_mdu(0, 0, 0, 0);
    step("mdu_cleared", mk(0, 0, 0, 0, 0));
    idle();
    set_mdu(1, 11, 0, 0);
    step("mdu_issue11", mk(0, 0, 0, 0, 0));
    set_mdu(0, 0, 0, 0);
    set_id(1, 1, 0, 11, 2'b01);
    set_stg(3'b001, 3'b111, 0, 0, 11);
    step("mdu_stage_overrides", mk(0, 1, 0, 0, 0));
    idle();
    set_mdu(0, 0, 1, 11);
    step("mdu_done11", mk(0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_errors++;
        $display("FAIL %s: no observation, required %b", e.name, e.v);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.v) begin
          n_errors++;
          $display("FAIL %s: got %b required %b", e.name, o, e.v);
        end else $display("check %s: %b", e.name, o);
      end
    end
  endtask

  task automatic test_same_cycle_and_full();
    exp_t e;
    logic [8:0] o;
    idle();
    set_mdu(1, 12, 0, 0);
    step("issue12", mk(0, 0, 0, 0, 0));
    set_mdu(1, 12, 1, 12);
    set_id(1, 1, 0, 12, 2'b01);
    step("same_cycle_done_sel", mk(0, 4, 0, 0, 0));
    set_mdu(0, 0, 0, 0);
    step("same_cycle_still_pending", mk(0, 0, 1, 0, 0));
    idle();
    for (int r = 1; r <= 3; r++) begin
      set_mdu(1, r, 0, 0);
      step("issue_fill", mk(0, 0, 0, 0, 0));
    end
    set_mdu(0, 0, 1, 12);
    set_id(1, 1, 0, 12, 2'b01);
    step("full_after_four", mk(0, 4, 0, 1, 0));
    idle();
    set_mdu(1, 0, 0, 0);
    step("full_cleared_by_done", mk(0, 0, 0, 0, 0));
    set_mdu(0, 0, 0, 0);
    step("reg0_issue_no_count", mk(0, 0, 0, 0, 0));
    set_mdu(0, 0, 1, 5);
    step("stray_done", mk(0, 0, 0, 0, 0));
    set_mdu(0, 0, 0, 0);
    step("stray_done_after", mk(0, 0, 0, 0, 0));
    set_mdu(1, 4, 0, 0);
    step("issue4", mk(0, 0, 0, 0, 0));
    set_mdu(0, 0, 0, 0);
    set_id(1, 1, 0, 0, 2'b01);
    set_stg(3'b001, 3'b110, 0, 0, 0);
    step("full_again_reg0_no_fwd", mk(0, 0, 0, 1, 0));
    idle();
    rst = 1'b1;
    step("reset_cycle_full", mk(0, 0, 0, 1, 0));
    rst = 1'b0;
    set_id(1, 1, 2, 1, 2'b11);
    step("reset_discards_pending", mk(0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_errors++;
        $display("FAIL %s: no observation, required %b", e.name, e.v);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.v) begin
          n_errors++;
          $display("FAIL %s: got %b required %b", e.name, o, e.v);
        end else $display("check %s: %b", e.name, o);
      end
    end
  endtask

  task automatic test_watchdog_reset();
    exp_t e;
    logic [8:0] o;
    idle();
    set_mdu(1, 7, 0, 0);
    step("issue7", mk(0, 0, 0, 0, 0));
    set_mdu(0, 0, 0, 0);
    set_id(1, 1, 0, 7, 2'b01);
    for (int i = 0; i < 64; i++) step("watchdog_counting", mk(0, 0, 1, 0, 0));
    idle();
    step("watchdog_tripped", mk(0, 0, 0, 0, 1));
    step("watchdog_sticky", mk(0, 0, 0, 0, 1));
    rst = 1'b1;
    step("watchdog_during_reset", mk(0, 0, 0, 0, 1));
    rst = 1'b0;
    set_id(1, 1, 0, 7, 2'b01);
    step("watchdog_after_reset", mk(0, 0, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_errors++;
        $display("FAIL %s: no observation, required %b", e.name, e.v);
      end else begin
        o = obs_q.pop_front();
        if (o !== e.v) begin
          n_errors++;
          $display("FAIL %s: got %b required %b", e.name, o, e.v);
        end else $display("check %s: %b", e.name, o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_operand_match();
    test_load_use();
    test_mdu();
    test_same_cycle_and_full();
    test_watchdog_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_fwd_scoreboard.md
Name: branch_fwd_scoreboard

Overview:
- ID-stage operand forwarding and hazard unit for branch resolution in the 5-stage MIPS pipeline. Next generation of the two-operand branch forwarding selector.
- Parametrised in operand count and number of forwarding stages.
- Adds stage-readiness stalls (load-use into branch) and a per-register scoreboard for the multi-cycle MDU.
- Adds a stall watchdog. Sits beside the ID-stage comparator and drives the operand muxes plus the pipeline stall line.

Parameters:
- REG_AW, 5, register address width (2**REG_AW registers; register 0 hardwired zero).
- NSRC, 2, number of ID operands checked.
- NSTAGE, 3, forwarding stages; index 0 = EX (nearest), 1 = MEM, 2 = WB.
- MAX_OUT, 4, max outstanding MDU writes.
- STALL_TIMEOUT, 64, consecutive stall cycles before watchdog trips.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_is_branch  in  1  ID instruction resolves a branch in ID
- id_src  in  NSRC*REG_AW  operand register numbers; operand i at [i*REG_AW +: REG_AW]
- id_src_used  in  NSRC  operand i is actually read
- stage_rd  in  NSTAGE*REG_AW  destination register per stage
- stage_we  in  NSTAGE  stage k will write stage_rd[k]
- stage_rdy  in  NSTAGE  result of stage k is available this cycle (0 for a load in EX)
- mdu_issue  in  1  MDU op accepted this cycle (qualified by !stall)
- mdu_issue_rd  in  REG_AW  MDU destination
- mdu_done  in  1  MDU result on write port this cycle
- mdu_done_rd  in  REG_AW  register being written by MDU
- fwd_sel  out  NSRC*SELW  per-operand source select; SELW = $clog2(NSTAGE+2)
- stall  out  1  hold PC/IF/ID, bubble into EX
- mdu_full  out  1  outstanding count == MAX_OUT; pipeline must not issue
- hazard_timeout  out  1  sticky watchdog flag

Behaviour:
- fwd_sel encoding: 0 = register file; k+1 = stage k; NSTAGE+1 = MDU write port. Combinational.
- Priority per operand s:
  - s == 0 or !id_src_used[i] → sel 0, no hazard.
  - Else the lowest k with stage_we[k] && stage_rd[k]==s → sel k+1.
  - Else mdu_done && mdu_done_rd==s → sel NSTAGE+1.
  - Else sel 0.
- Ready hazard: the selected stage k has stage_rdy[k]==0 and id_valid && id_is_branch. Non-branch ID consumers forward later in EX, so they do not stall on readiness.
- MDU hazard: pending[s]==1, no stage match, and not (mdu_done && mdu_done_rd==s). Applies to any id_valid instruction.
- stall = OR of both hazards over all operands. Combinational, same cycle.
- Scoreboard:
  - pending[2**REG_AW] bit vector and outstanding counter out_cnt (width $clog2(MAX_OUT+1)), updated on clk.
  - Issue sets pending[mdu_issue_rd] and increments out_cnt. Done clears pending[mdu_done_rd] and decrements out_cnt.
  - Issue and done in the same cycle:
    - Same register → bit stays set, out_cnt unchanged.
    - Different registers → both applied, out_cnt unchanged.
  - Issue to register 0 → ignored entirely, no count.
  - Done with pending clear → bit stays 0, out_cnt unchanged.
  - Issue while mdu_full → ignored (protocol error; assertion in sim).
- mdu_full = (out_cnt == MAX_OUT), registered-state derived.
- Watchdog:
  - stall_ctr increments each cycle stall==1 and clears when stall==0. It saturates at STALL_TIMEOUT.
  - On reaching STALL_TIMEOUT, hazard_timeout is set and held until rst.
- Reset (synchronous): pending all 0, out_cnt 0, stall_ctr 0, hazard_timeout 0, mdu_full 0. With id_valid=0, stall=0 and fwd_sel=0.
- Reset mid-operation discards all outstanding MDU state. The pipeline flushes the MDU concurrently.

Optional Feature:
- Macro BRANCH_STALL_STATS_EN.
- When defined, adds outputs stat_ready_stalls [31:0] and stat_mdu_stalls [31:0]:
  - Each counts cycles in which that hazard class asserted stall; both count if both hazards assert.
  - Wrap at 2**32; cleared by rst.
- When undefined, the ports are absent and no counters are built.

Decomposition:
- Package fwd_pkg holds the SELW function and the FWD_RF/FWD_MDU select-code constants, shared with the ID comparator muxes and the EX forwarding unit.
- One natural sub-module, mdu_scoreboard: the pending vector, out_cnt, mdu_full and the lookup port. The parent keeps the match/priority logic and the watchdog.

Test Plan:
- Operand match: branch id_src={rt=9,rs=8}; stage_we=3'b110, stage_rd={WB=8, MEM=8, EX=x}, stage_rdy=3'b111 → rs sel 2 (MEM beats WB), rt sel 0, stall=0.
- Load-use into branch: EX rd=8, we=1, rdy=0; branch reads 8 → stall=1 for one cycle. Next cycle the load is in MEM with rdy=1 → sel 2, stall=0.
- MDU scoreboard: issue rd=10. A branch reading 10 stalls until mdu_done rd=10. In the done cycle sel=NSTAGE+1=4 and stall=0; pending[10] is clear the following cycle.
- Same-cycle issue/done on register 12 → pending[12] stays 1, out_cnt unchanged. Four issues to 1,2,3,4 → mdu_full=1; one done → mdu_full=0 the next cycle.
- Register 0 and unused operands: id_src=0 with EX rd=0 we=1 rdy=0 → sel 0, stall=0. Issue to rd=0 → out_cnt unchanged.
- Watchdog and reset: hold an MDU hazard for 64 cycles → hazard_timeout=1 and stays 1 after the hazard clears. Assert rst one cycle → all state cleared and hazard_timeout=0 the following cycle.
